abc_display_regs: RTL and testbench
===================================

ABC_DISPLAY_REGS -- requirements
Module: abc_display_regs

Interface
REQ-001 SHALL have parameter C_S_AXI_DATA_WIDTH, default 32, AXI4-Lite data width (only 32 supported).
REQ-002 SHALL have parameter C_S_AXI_ADDR_WIDTH, default 5, AXI4-Lite byte address width.
REQ-003 s00_axi_aclk  in  1  single clock; all logic on rising edge.
REQ-004 s00_axi_areset  in  1  reset, synchronous, active-high.
REQ-005 s00_axi_awaddr  in  5  write address; s00_axi_awprot  in  3  ignored; s00_axi_awvalid  in  1; s00_axi_awready  out  1.
REQ-006 s00_axi_wdata  in  32; s00_axi_wstrb  in  4  byte enables; s00_axi_wvalid  in  1; s00_axi_wready  out  1.
REQ-007 s00_axi_bresp  out  2; s00_axi_bvalid  out  1; s00_axi_bready  in  1.
REQ-008 s00_axi_araddr  in  5; s00_axi_arprot  in  3  ignored; s00_axi_arvalid  in  1; s00_axi_arready  out  1.
REQ-009 s00_axi_rdata  out  32; s00_axi_rresp  out  2; s00_axi_rvalid  out  1; s00_axi_rready  in  1.
REQ-010 reg0_o..reg3_o  out  32 each  current contents of RW registers 0-3 to display logic.
REQ-011 status_i  in  32  read-only status word from display logic.
REQ-012 wr_pulse_o  out  4  one-cycle strobe per register 0-3 on commit of a write to it.

Function
REQ-013 Register index SHALL be addr[4:2]; addr[1:0] ignored.
REQ-014 Map: idx 0-3 RW registers, OKAY; idx 4 read returns status_i, OKAY, write ignored with OKAY; idx 5-7 read 0 with SLVERR (2'b10), write ignored with SLVERR.
REQ-015 Write path states: IDLE, HAVE_AW, HAVE_W, COMMIT, RESP.
REQ-016 awready SHALL be 1 in IDLE and HAVE_W only; wready SHALL be 1 in IDLE and HAVE_AW only.
REQ-017 AW and W handshakes SHALL be accepted independently in either order or same cycle; address and data/strobe latched at their handshake.
REQ-018 Once both latched, state SHALL be COMMIT for exactly one cycle; on the edge ending COMMIT the target register updates byte-wise per wstrb (strobe 0 bytes unchanged), wr_pulse_o[idx] pulses only if idx 0-3 and wstrb != 0, bvalid rises, state RESP.
REQ-019 Latency: AW+W same-cycle handshake at edge N -> bvalid visible after edge N+2.
REQ-020 bvalid and bresp SHALL hold stable until bready; B handshake returns to IDLE; no new AW/W accepted while in COMMIT or RESP.
REQ-021 Read path: arready = !rvalid; AR handshake at edge N -> rvalid, rdata, rresp valid after edge N (next cycle), held stable until rready.
REQ-022 rdata SHALL be sampled at the AR handshake edge; a write committing on that same edge to the same register returns the pre-write value.
REQ-023 R handshake clears rvalid; a new AR may be accepted the cycle after rvalid clears (no back-to-back in same cycle).
REQ-024 Read and write paths SHALL operate concurrently without interaction beyond REQ-022.
REQ-025 wr_pulse_o SHALL be 0 in all cycles other than those following a qualifying commit.

Reset
REQ-026 While s00_axi_areset=1 at an edge: write state IDLE, holding registers cleared, reg0_o..reg3_o = 0, awready=wready=arready=0 during reset cycle, then 1,1,1 in first cycle after release; bvalid=rvalid=0, bresp=rresp=0, rdata=0, wr_pulse_o=0.
REQ-027 Reset mid-transaction SHALL abandon any latched AW/W or pending B/R response with no register update and no response issued.

Verification
REQ-028 Write 1,2,3,4 to 0x0,0x4,0x8,0xC (wstrb 0xF), then read same -> each BRESP/RRESP OKAY, reads return 1,2,3,4; reg0_o..reg3_o = 1,2,3,4; one wr_pulse_o bit per write.
REQ-029 W before AW by 3 cycles to 0x4 data 0xAABBCCDD -> wready low after W handshake, bvalid 2 cycles after AW handshake, reg1_o = 0xAABBCCDD.
REQ-030 reg2=0x11223344, write 0x8 data 0xFFFFFFFF wstrb 0x5 -> reg2_o = 0x11FF33FF.
REQ-031 bready held low 10 cycles after bvalid -> bvalid/bresp stable, awready/wready low throughout; rready low 10 cycles -> rdata stable, arready low.
REQ-032 Read 0x10 with status_i=0xCAFE0001 -> rdata 0xCAFE0001 OKAY; read 0x18 -> rdata 0 SLVERR; write 0x1C -> BRESP SLVERR, no wr_pulse_o.
REQ-033 Assert reset one cycle after AW handshake to 0x0 (W not yet sent) -> no bvalid, reg0_o = 0, awready/wready = 1 after release.

Source files
------------

// File: rtl/abc_display_regs.sv
// AXI4-Lite slave with four RW display registers, a read-only status word and per-register write strobes.
// The write path captures AW and W independently, then commits; the read path holds one response until it is accepted.
module abc_display_regs #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 5
) (
    input  logic                              s00_axi_aclk,
    input  logic                              s00_axi_areset,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     s00_axi_awaddr,
    input  logic [2:0]                        s00_axi_awprot,
    input  logic                              s00_axi_awvalid,
    output logic                              s00_axi_awready,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]     s00_axi_wdata,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   s00_axi_wstrb,
    input  logic                              s00_axi_wvalid,
    output logic                              s00_axi_wready,
    output logic [1:0]                        s00_axi_bresp,
    output logic                              s00_axi_bvalid,
    input  logic                              s00_axi_bready,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     s00_axi_araddr,
    input  logic [2:0]                        s00_axi_arprot,
    input  logic                              s00_axi_arvalid,
    output logic                              s00_axi_arready,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     s00_axi_rdata,
    output logic [1:0]                        s00_axi_rresp,
    output logic                              s00_axi_rvalid,
    input  logic                              s00_axi_rready,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     reg0_o,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     reg1_o,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     reg2_o,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     reg3_o,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]     status_i,
    output logic [3:0]                        wr_pulse_o
);

    localparam int         C_STRB_W    = C_S_AXI_DATA_WIDTH / 8;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // state    | meaning
    // IDLE     | nothing latched, AW and W both accepted
    // HAVE_AW  | address latched, waiting for (or settling) write data
    // HAVE_W   | data latched, waiting for (or settling) write address
    // COMMIT   | both latched, register update on the edge leaving this state
    // RESP     | write response held until bready
    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_HAVE_AW = 3'd1,
        S_HAVE_W  = 3'd2,
        S_COMMIT  = 3'd3,
        S_RESP    = 3'd4
    } wr_state_t;

    wr_state_t r_state;
    wr_state_t w_state_next;

    logic                          r_ready_en;
    logic                          r_aw_full;
    logic                          r_w_full;
    logic [2:0]                    r_aw_idx;
    logic [C_S_AXI_DATA_WIDTH-1:0] r_wdata;
    logic [C_STRB_W-1:0]           r_wstrb;
    logic [C_S_AXI_DATA_WIDTH-1:0] r_regs [4];
    logic                          r_bvalid;
    logic [1:0]                    r_bresp;
    logic [3:0]                    r_wr_pulse;
    logic                          r_rvalid;
    logic [1:0]                    r_rresp;
    logic [C_S_AXI_DATA_WIDTH-1:0] r_rdata;

    logic                          w_aw_hs;
    logic                          w_w_hs;
    logic                          w_ar_hs;
    logic [2:0]                    w_ar_idx;
    logic [C_S_AXI_DATA_WIDTH-1:0] w_rd_data;
    logic [1:0]                    w_rd_resp;
    logic [1:0]                    w_wr_resp;
    logic                          w_unused;

    assign w_unused = ^{s00_axi_awprot, s00_axi_arprot, s00_axi_awaddr[1:0], s00_axi_araddr[1:0]};

    // Ready flags are also gated by the per-channel full bits so a latched side is never overwritten.
    assign s00_axi_awready = r_ready_en && !r_aw_full && (r_state == S_IDLE || r_state == S_HAVE_W);
    assign s00_axi_wready  = r_ready_en && !r_w_full  && (r_state == S_IDLE || r_state == S_HAVE_AW);
    assign s00_axi_arready = r_ready_en && !r_rvalid;

    assign w_aw_hs  = s00_axi_awvalid && s00_axi_awready;
    assign w_w_hs   = s00_axi_wvalid  && s00_axi_wready;
    assign w_ar_hs  = s00_axi_arvalid && s00_axi_arready;
    assign w_ar_idx = s00_axi_araddr[4:2];

    assign s00_axi_bvalid = r_bvalid;
    assign s00_axi_bresp  = r_bresp;
    assign s00_axi_rvalid = r_rvalid;
    assign s00_axi_rresp  = r_rresp;
    assign s00_axi_rdata  = r_rdata;
    assign wr_pulse_o     = r_wr_pulse;
    assign reg0_o         = r_regs[0];
    assign reg1_o         = r_regs[1];
    assign reg2_o         = r_regs[2];
    assign reg3_o         = r_regs[3];

    always_ff @(posedge s00_axi_aclk) begin
        if (s00_axi_areset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_aw_hs) begin
                    w_state_next = S_HAVE_AW;
                end else if (w_w_hs) begin
                    w_state_next = S_HAVE_W;
                end
            end
            S_HAVE_AW, S_HAVE_W: begin
                if (r_aw_full && r_w_full) begin
                    w_state_next = S_COMMIT;
                end
            end
            S_COMMIT: w_state_next = S_RESP;
            S_RESP: begin
                if (s00_axi_bready) begin
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_rd_data = '0;
        w_rd_resp = RESP_OKAY;
        case (w_ar_idx)
            3'd0, 3'd1, 3'd2, 3'd3: w_rd_data = r_regs[w_ar_idx[1:0]];
            3'd4:                   w_rd_data = status_i;
            default:                w_rd_resp = RESP_SLVERR;
        endcase
    end

    assign w_wr_resp = (r_aw_idx <= 3'd4) ? RESP_OKAY : RESP_SLVERR;

    always_ff @(posedge s00_axi_aclk) begin
        if (s00_axi_areset) begin
            r_ready_en <= 1'b0;
            r_aw_full  <= 1'b0;
            r_w_full   <= 1'b0;
            r_aw_idx   <= '0;
            r_wdata    <= '0;
            r_wstrb    <= '0;
            r_bvalid   <= 1'b0;
            r_bresp    <= RESP_OKAY;
            r_wr_pulse <= '0;
            for (int i = 0; i < 4; i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            r_ready_en <= 1'b1;
            r_wr_pulse <= '0;
            if (w_aw_hs) begin
                r_aw_full <= 1'b1;
                r_aw_idx  <= s00_axi_awaddr[4:2];
            end
            if (w_w_hs) begin
                r_w_full <= 1'b1;
                r_wdata  <= s00_axi_wdata;
                r_wstrb  <= s00_axi_wstrb;
            end
            if (r_state == S_COMMIT) begin
                r_aw_full <= 1'b0;
                r_w_full  <= 1'b0;
                r_bvalid  <= 1'b1;
                r_bresp   <= w_wr_resp;
                if (!r_aw_idx[2]) begin
                    for (int b = 0; b < C_STRB_W; b++) begin
                        if (r_wstrb[b]) begin
                            r_regs[r_aw_idx[1:0]][8*b +: 8] <= r_wdata[8*b +: 8];
                        end
                    end
                    if (|r_wstrb) begin
                        r_wr_pulse[r_aw_idx[1:0]] <= 1'b1;
                    end
                end
            end
            if (r_state == S_RESP && s00_axi_bready) begin
                r_bvalid <= 1'b0;
            end
        end
    end

    // Read data is captured from the pre-edge register values, so a same-edge commit is not visible.
    always_ff @(posedge s00_axi_aclk) begin
        if (s00_axi_areset) begin
            r_rvalid <= 1'b0;
            r_rresp  <= RESP_OKAY;
            r_rdata  <= '0;
        end else if (w_ar_hs) begin
            r_rvalid <= 1'b1;
            r_rresp  <= w_rd_resp;
            r_rdata  <= w_rd_data;
        end else if (r_rvalid && s00_axi_rready) begin
            r_rvalid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_abc_display_regs.sv
// Directed bench for abc_display_regs: tasks drive AXI transactions and queue expected responses,
// a negedge monitor pops and compares B/R responses as the DUT presents them.
module tb_abc_display_regs;

    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [4:0]  awaddr = '0;
    logic [2:0]  awprot = '0;
    logic        awvalid = 1'b0;
    logic        awready;
    logic [31:0] wdata = '0;
    logic [3:0]  wstrb = '0;
    logic        wvalid = 1'b0;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready = 1'b1;
    logic [4:0]  araddr = '0;
    logic [2:0]  arprot = '0;
    logic        arvalid = 1'b0;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready = 1'b1;
    logic [31:0] reg0, reg1, reg2, reg3;
    logic [31:0] status = '0;
    logic [3:0]  wr_pulse;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int pulse_total = 0;
    int exp_pulses = 0;

    logic [1:0]  bq[$];
    logic [33:0] rq[$];

    abc_display_regs dut (
        .s00_axi_aclk   (clk),
        .s00_axi_areset (rst),
        .s00_axi_awaddr (awaddr),
        .s00_axi_awprot (awprot),
        .s00_axi_awvalid(awvalid),
        .s00_axi_awready(awready),
        .s00_axi_wdata  (wdata),
        .s00_axi_wstrb  (wstrb),
        .s00_axi_wvalid (wvalid),
        .s00_axi_wready (wready),
        .s00_axi_bresp  (bresp),
        .s00_axi_bvalid (bvalid),
        .s00_axi_bready (bready),
        .s00_axi_araddr (araddr),
        .s00_axi_arprot (arprot),
        .s00_axi_arvalid(arvalid),
        .s00_axi_arready(arready),
        .s00_axi_rdata  (rdata),
        .s00_axi_rresp  (rresp),
        .s00_axi_rvalid (rvalid),
        .s00_axi_rready (rready),
        .reg0_o         (reg0),
        .reg1_o         (reg1),
        .reg2_o         (reg2),
        .reg3_o         (reg3),
        .status_i       (status),
        .wr_pulse_o     (wr_pulse)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Response monitor / scoreboard
    always @(negedge clk) begin
        logic [33:0] re;
        if (bvalid === 1'b1 && bready) begin
            if (bq.size() == 0) begin
                chk("b_unexpected", 64'(bvalid), 64'(0));
            end else begin
                chk("bresp", 64'(bresp), 64'(bq.pop_front()));
            end
        end
        if (rvalid === 1'b1 && rready) begin
            if (rq.size() == 0) begin
                chk("r_unexpected", 64'(rvalid), 64'(0));
            end else begin
                re = rq.pop_front();
                chk("rresp", 64'(rresp), 64'(re[33:32]));
                chk("rdata", 64'(rdata), 64'(re[31:0]));
            end
        end
        if (!$isunknown(wr_pulse)) pulse_total += $countones(wr_pulse);
    end

    task automatic axi_write(input logic [4:0] addr, input logic [31:0] data, input logic [3:0] strb,
                             input logic [1:0] exp_resp, input logic [3:0] exp_pulse,
                             input int lead, input bit stall);
        int  n;
        int  hs_cyc;
        int  since_w;
        bit  aw_done, w_done, aw_hit, w_hit, seen;
        bq.push_back(exp_resp);
        exp_pulses += $countones(exp_pulse);
        if (stall) bready = 1'b0;
        awaddr  = addr;
        wdata   = data;
        wstrb   = strb;
        wvalid  = 1'b1;
        awvalid = (lead == 0);
        aw_done = 0; w_done = 0; n = 0; hs_cyc = 0; since_w = 0;
        while (!(aw_done && w_done) && n < 40) begin
            @(negedge clk);
            aw_hit = awvalid && awready;
            w_hit  = wvalid && wready;
            if (lead > 0 && w_done && !aw_done) chk("wready_after_w", 64'(wready), 64'(0));
            @(posedge clk); #1;
            if (w_done) since_w++;
            if (aw_hit) begin awvalid = 1'b0; aw_done = 1; hs_cyc = cyc; end
            if (w_hit)  begin wvalid = 1'b0;  w_done = 1;  hs_cyc = cyc; since_w = 0; end
            if (lead > 0 && w_done && !aw_done && since_w == lead - 1) awvalid = 1'b1;
            n++;
        end
        awvalid = 1'b0;
        wvalid  = 1'b0;
        chk("aw_w_handshake", 64'({aw_done, w_done}), 64'(2'b11));
        n = 0; seen = 0;
        while (!seen && n < 20) begin
            @(negedge clk);
            seen = bvalid;
            n++;
        end
        chk("b_valid_seen", 64'(seen), 64'(1));
        chk("b_latency", 64'(cyc - hs_cyc), 64'(2));
        chk("wr_pulse", 64'(wr_pulse), 64'(exp_pulse));
        if (stall) begin
            repeat (10) begin
                @(posedge clk); @(negedge clk);
                chk("b_stall", 64'({bvalid, bresp, awready, wready}), 64'({1'b1, exp_resp, 2'b00}));
            end
            @(posedge clk); #1;
            bready = 1'b1;
            @(negedge clk);
        end
        @(posedge clk); #1;
    endtask

    task automatic axi_read(input logic [4:0] addr, input logic [31:0] exp_data,
                            input logic [1:0] exp_resp, input bit stall);
        int n;
        bit hit;
        rq.push_back({exp_resp, exp_data});
        if (stall) rready = 1'b0;
        araddr  = addr;
        arvalid = 1'b1;
        n = 0; hit = 0;
        while (!hit && n < 20) begin
            @(negedge clk);
            hit = arready;
            @(posedge clk); #1;
            n++;
        end
        arvalid = 1'b0;
        chk("ar_handshake", 64'(hit), 64'(1));
        @(negedge clk);
        chk("r_latency", 64'(rvalid), 64'(1));
        if (stall) begin
            repeat (10) begin
                @(posedge clk); @(negedge clk);
                chk("r_stall", 64'({rvalid, rresp, arready, rdata}), 64'({1'b1, exp_resp, 1'b0, exp_data}));
            end
            @(posedge clk); #1;
            rready = 1'b1;
            @(negedge clk);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        bit hit;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", 64'({awready, wready, arready}), 64'(3'b000));
        chk("rst_valid", 64'({bvalid, rvalid, bresp, rresp}), 64'(0));
        chk("rst_rdata", 64'(rdata), 64'(0));
        chk("rst_pulse", 64'(wr_pulse), 64'(0));
        chk("rst_regs", 64'(reg0 | reg1 | reg2 | reg3), 64'(0));
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("post_rst_ready", 64'({awready, wready, arready}), 64'(3'b111));
        @(posedge clk); #1;

        // basic write/read of all four registers
        axi_write(5'h00, 32'd1, 4'hF, OKAY, 4'b0001, 0, 0);
        axi_write(5'h04, 32'd2, 4'hF, OKAY, 4'b0010, 0, 0);
        axi_write(5'h08, 32'd3, 4'hF, OKAY, 4'b0100, 0, 0);
        axi_write(5'h0C, 32'd4, 4'hF, OKAY, 4'b1000, 0, 0);
        axi_read(5'h00, 32'd1, OKAY, 0);
        axi_read(5'h04, 32'd2, OKAY, 0);
        axi_read(5'h08, 32'd3, OKAY, 0);
        axi_read(5'h0C, 32'd4, OKAY, 0);
        chk("regs_1234", {reg0[15:0], reg1[15:0], reg2[15:0], reg3[15:0]}, 64'h0001_0002_0003_0004);

        // W leads AW by three cycles
        axi_write(5'h04, 32'hAABBCCDD, 4'hF, OKAY, 4'b0010, 3, 0);
        chk("reg1_w_first", 64'(reg1), 64'hAABBCCDD);

        // byte strobes
        axi_write(5'h08, 32'h11223344, 4'hF, OKAY, 4'b0100, 0, 0);
        axi_write(5'h08, 32'hFFFFFFFF, 4'h5, OKAY, 4'b0100, 0, 0);
        chk("reg2_strobe", 64'(reg2), 64'h11FF33FF);
        axi_write(5'h00, 32'hDEADBEEF, 4'h0, OKAY, 4'b0000, 0, 0);
        chk("reg0_zero_strb", 64'(reg0), 64'd1);

        // back-pressure on B and R
        axi_write(5'h0C, 32'h00000055, 4'hF, OKAY, 4'b1000, 0, 1);
        axi_read(5'h0C, 32'h00000055, OKAY, 1);

        // status word and unmapped slots
        status = 32'hCAFE0001;
        axi_read(5'h10, 32'hCAFE0001, OKAY, 0);
        axi_read(5'h18, 32'h0, SLVERR, 0);
        axi_read(5'h14, 32'h0, SLVERR, 0);
        axi_write(5'h1C, 32'h12345678, 4'hF, SLVERR, 4'b0000, 0, 0);
        axi_write(5'h10, 32'h12345678, 4'hF, OKAY, 4'b0000, 0, 0);
        axi_read(5'h07, 32'hAABBCCDD, OKAY, 0);
        chk("regs_after_unmapped", {reg0, reg3}, {32'd1, 32'h55});

        // read handshake on the same edge as a commit to that register returns the old value
        fork
            axi_write(5'h00, 32'h77, 4'hF, OKAY, 4'b0001, 0, 0);
            begin
                repeat (2) @(posedge clk);
                #1;
                axi_read(5'h00, 32'd1, OKAY, 0);
            end
        join
        axi_read(5'h00, 32'h77, OKAY, 0);

        // reset in the middle of a write with only AW accepted
        awaddr  = 5'h00;
        awvalid = 1'b1;
        @(negedge clk);
        hit = awready;
        @(posedge clk); #1;
        awvalid = 1'b0;
        chk("aw_before_reset", 64'(hit), 64'(1));
        @(posedge clk); #1;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("mid_rst_ready", 64'({awready, wready}), 64'(2'b11));
        chk("mid_rst_reg0", 64'(reg0), 64'(0));
        repeat (4) begin
            @(posedge clk); @(negedge clk);
            chk("mid_rst_no_b", 64'({bvalid, wr_pulse}), 64'(0));
        end
        @(posedge clk); #1;

        axi_write(5'h00, 32'h12345678, 4'hF, OKAY, 4'b0001, 0, 0);
        chk("reg0_after_mid_rst", 64'(reg0), 64'h12345678);

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("b_queue_drained", 64'(bq.size()), 64'(0));
        chk("r_queue_drained", 64'(rq.size()), 64'(0));
        chk("pulse_total", 64'(pulse_total), 64'(exp_pulses));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
